regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port register file with an integrated scoreboard for the decode stage. It holds the architectural registers and forwards same-cycle writeback data to readers. It tracks which registers have an outstanding producer and reports that per read port so decode can stall. After reset it clears the storage array with a sweep state machine, so the array can map to plain RAM without a reset network.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never pending

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  registered pending flag of the register read on port p
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  issue strobe: mark iss_addr as having an outstanding producer
- iss_addr  in  ADDR_W  destination of issued instruction
- init_done  out  1  high once the clear sweep has finished
- pend_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- FSM states: INIT, RUN. Reset forces INIT with sweep index 0.
- INIT: one entry is written with 0 per cycle, index 0..DEPTH-1. rd_en, wr_en and iss_en are ignored. rd_data and rd_pend hold 0. After index DEPTH-1 the FSM goes to RUN.
- RUN, read: on a clock edge with rd_en[p]=1, rd_data[p] is loaded with the register contents and rd_pend[p] with its pending bit. With rd_en[p]=0, both outputs hold their previous value.
- Bypass: if wr_en=1 and wr_addr equals rd_addr[p] in the same cycle, rd_data[p] takes wr_data. rd_pend[p] then reflects the post-update pending state.
- Write: wr_en stores wr_data and clears the pending bit of wr_addr. A write to a register that is not pending is legal and changes no count.
- Issue: iss_en sets the pending bit of iss_addr. Issuing to an already-pending register leaves it pending and does not change the count.
- Simultaneous issue and write to the same address: data is written and pending ends set, because the issue wins.
- pend_cnt:
  - +1 when a non-pending register becomes pending.
  - -1 when a pending register is cleared.
  - Both updates apply in the same cycle when the addresses differ.
  - The range is 0..DEPTH; no wrap is possible.
- ZERO_REG=1:
  - Writes and issues to address 0 are ignored.
  - Reads of address 0 return 0 with rd_pend=0, including under bypass.
- All read ports are independent. Any number of ports may read the same address.

## Timing
- Reset values: rd_data=0, rd_pend=0, init_done=0, pend_cnt=0, all pending bits 0. Array contents are undefined until the sweep completes.
- Sweep length is DEPTH cycles. init_done rises on the edge that writes entry DEPTH-1 and stays high until the next reset.
- Read latency is 1 cycle, from the rd_en/rd_addr edge to valid rd_data/rd_pend.
- Write-to-read latency is 0 extra cycles thanks to bypass. A write at edge N is seen by a read issued at edge N.
- Issue-to-pend latency is 0 extra cycles. A read at the same edge as the issue reports rd_pend=1.
- Reset asserted mid-operation immediately zeroes outputs and all pending bits and returns the FSM to INIT. In-flight writes are lost.

## Test plan
- Reset, then idle with default parameters -> init_done rises exactly 32 cycles after rst_n deasserts. All 32 registers then read 0 with rd_pend=0.
- Write 0xDEADBEEF to r5 while port 0 reads r5 and port 1 reads r0 in the same cycle -> next cycle rd_data[0]=0xDEADBEEF, rd_data[1]=0, both rd_pend=0.
- Issue r7, then read r7 on both ports -> rd_pend=2'b11 and pend_cnt=1. Writeback r7=0x12 -> a following read gives 0x12, rd_pend=0, pend_cnt=0.
- Same-cycle issue and write to r3 while r3 is not pending -> r3 holds wr_data, reads pending, pend_cnt=1. Repeat with r3 already pending -> pend_cnt unchanged.
- Issue r0 and write 0x55 to r0 with ZERO_REG=1 -> a read returns 0, rd_pend=0, pend_cnt=0.
- Issue r1..r4, then pulse rst_n low mid-stream -> pend_cnt=0, init_done=0, rd_data=0 immediately. The sweep repeats and afterwards all registers read 0 and non-pending.

Source files
------------

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/writeback/issue bundle for the register file with scoreboard
//
// Purpose: groups the decode-side read ports, the writeback port, the issue
// port and the status outputs of regfile_sb.
// Ports (master = decode/writeback side, slave = regfile_sb):
//   rd_en/rd_addr        -> read request per port, port p at [p*ADDR_W +: ADDR_W]
//   rd_data/rd_pend      <- registered read data / pending flag per port
//   wr_en/wr_addr/wr_data -> writeback strobe, address, data
//   iss_en/iss_addr      -> mark a destination as having an outstanding producer
//   init_done            <- clear sweep finished
//   pend_cnt             <- number of registers currently pending
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     init_done;
    logic [ADDR_W:0]          pend_cnt;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_pend, init_done, pend_cnt
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_pend, init_done, pend_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with writeback bypass and scoreboard
//
// Purpose: architectural register file for decode. Reads are registered (1 cycle),
// same-cycle writeback is forwarded to readers, and a pending bit per register
// tracks outstanding producers so decode can stall. After reset a sweep FSM
// writes zero to every entry, so the storage array itself carries no reset.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - regfile_sb_if slave modport (read, writeback, issue, status)
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic                     init_done_q, init_done_d;
    logic [DEPTH-1:0]         pend_q, pend_d;
    logic [ADDR_W:0]          cnt_q, cnt_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_pend_q, rd_pend_d;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;

    logic                     wr_ok, iss_ok, cnt_inc, cnt_dec;
    logic [ADDR_W-1:0]        ra;

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        rd_pend_d   = rd_pend_q;
        mem_we      = 1'b0;
        mem_waddr   = bus.wr_addr;
        mem_wdata   = bus.wr_data;
        wr_ok       = 1'b0;
        iss_ok      = 1'b0;
        cnt_inc     = 1'b0;
        cnt_dec     = 1'b0;
        ra          = '0;

        case (state_q)
            ST_INIT: begin
                // Clear one entry per cycle; all requests are ignored meanwhile.
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                wr_ok  = bus.wr_en  && !is_zero(bus.wr_addr);
                iss_ok = bus.iss_en && !is_zero(bus.iss_addr);
                mem_we = wr_ok;

                // Clear before set so an issue to the written register wins.
                if (wr_ok)  pend_d[bus.wr_addr]  = 1'b0;
                if (iss_ok) pend_d[bus.iss_addr] = 1'b1;

                // Same-address issue+write nets to "stays/becomes pending":
                // the clear is suppressed, only a 0->1 transition counts.
                cnt_inc = iss_ok && !pend_q[bus.iss_addr];
                cnt_dec = wr_ok && pend_q[bus.wr_addr] &&
                          !(iss_ok && (bus.iss_addr == bus.wr_addr));
                cnt_d   = cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);

                for (int p = 0; p < NUM_RD; p++) begin
                    if (bus.rd_en[p]) begin
                        ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
                        if (is_zero(ra)) begin
                            rd_data_d[p*DATA_W +: DATA_W] = '0;
                            rd_pend_d[p]                  = 1'b0;
                        end else begin
                            rd_data_d[p*DATA_W +: DATA_W] =
                                (wr_ok && (bus.wr_addr == ra)) ? bus.wr_data : mem[ra];
                            // Post-update view: same-cycle issue/write are visible.
                            rd_pend_d[p] = pend_d[ra];
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            pend_q      <= '0;
            cnt_q       <= '0;
            rd_data_q   <= '0;
            rd_pend_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // Storage has no reset; the INIT sweep provides the known-zero contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_pend   = rd_pend_q;
    assign bus.init_done = init_done_q;
    assign bus.pend_cnt  = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
module tb_regfile_sb;
    logic clk;
    logic rst_n;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: register values, pending flags, expected port outputs.
    logic [31:0] m_mem [32];
    logic        m_pend [32];
    logic [31:0] e_d [2];
    logic        e_p [2];

    typedef struct {
        logic [1:0]  re;
        logic [4:0]  a0, a1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [31:0] d0, d1;
        logic [1:0]  p;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] p, input logic [5:0] cnt);
        vec_t v;
        v.re = re; v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.wd = wd;
        v.ie = ie; v.ia = ia; v.d0 = d0; v.d1 = d1; v.p = p; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        e_d[0] = '0; e_d[1] = '0;
        e_p[0] = 1'b0; e_p[1] = 1'b0;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic wait_init(output int n);
        n = 0;
        while (bus.init_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    // Drive one clock of requests, advance, update the model, compare.
    task automatic cycle(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia);
        logic [4:0] a [2];
        bus.rd_en    = re;
        bus.rd_addr  = {a1, a0};
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.iss_en   = ie;
        bus.iss_addr = ia;
        step();
        a[0] = a0; a[1] = a1;
        if (we && wa != 5'd0) begin
            m_mem[wa]  = wd;
            m_pend[wa] = 1'b0;
        end
        if (ie && ia != 5'd0) m_pend[ia] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            if (re[p]) begin
                e_d[p] = (a[p] == 5'd0) ? 32'd0 : m_mem[a[p]];
                e_p[p] = (a[p] == 5'd0) ? 1'b0  : m_pend[a[p]];
            end
        end
        chk("rd_data0", 64'(bus.rd_data[31:0]),  64'(e_d[0]));
        chk("rd_data1", 64'(bus.rd_data[63:32]), 64'(e_d[1]));
        chk("rd_pend",  64'(bus.rd_pend),        64'({e_p[1], e_p[0]}));
        chk("pend_cnt", 64'(bus.pend_cnt),       64'(model_count()));
    endtask

    initial begin
        int n;
        tbl[0]  = mk(2'b11, 5'd5,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF, 32'h0, 2'b00, 6'd0);
        tbl[1]  = mk(2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h0,        32'h0, 2'b11, 6'd1);
        tbl[2]  = mk(2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0, 2'b11, 6'd1);
        tbl[3]  = mk(2'b00, 5'd7,  5'd7,  1'b1, 5'd7,  32'h12,       1'b0, 5'd0,  32'h0,        32'h0, 2'b11, 6'd0);
        tbl[4]  = mk(2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h12,       32'h12, 2'b00, 6'd0);
        tbl[5]  = mk(2'b11, 5'd3,  5'd3,  1'b1, 5'd3,  32'hA5,       1'b1, 5'd3,  32'hA5,       32'hA5, 2'b11, 6'd1);
        tbl[6]  = mk(2'b11, 5'd3,  5'd5,  1'b1, 5'd3,  32'hB6,       1'b1, 5'd3,  32'hB6,       32'hDEADBEEF, 2'b01, 6'd1);
        tbl[7]  = mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd0,  32'h55,       1'b1, 5'd0,  32'h0,        32'h0, 2'b00, 6'd1);
        tbl[8]  = mk(2'b11, 5'd3,  5'd0,  1'b1, 5'd3,  32'h77,       1'b0, 5'd0,  32'h77,       32'h0, 2'b00, 6'd0);
        tbl[9]  = mk(2'b01, 5'd5,  5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hDEADBEEF, 32'h0, 2'b00, 6'd0);
        tbl[10] = mk(2'b10, 5'd5,  5'd9,  1'b1, 5'd9,  32'h1,        1'b0, 5'd0,  32'hDEADBEEF, 32'h1, 2'b00, 6'd0);
        tbl[11] = mk(2'b11, 5'd10, 5'd10, 1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h0,        32'h0, 2'b11, 6'd1);
        tbl[12] = mk(2'b11, 5'd10, 5'd11, 1'b1, 5'd10, 32'hAB,       1'b1, 5'd11, 32'hAB,       32'h0, 2'b10, 6'd1);

        // Reset with junk requests present; they must also be ignored during the sweep.
        rst_n        = 1'b0;
        bus.rd_en    = 2'b11;
        bus.rd_addr  = {5'd5, 5'd5};
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd5;
        bus.wr_data  = 32'hFFFF_FFFF;
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd3;
        model_reset();
        repeat (3) step();
        chk("reset_rd_data",   64'(bus.rd_data),   64'd0);
        chk("reset_rd_pend",   64'(bus.rd_pend),   64'd0);
        chk("reset_init_done", 64'(bus.init_done), 64'd0);
        chk("reset_pend_cnt",  64'(bus.pend_cnt),  64'd0);

        rst_n = 1'b1;
        wait_init(n);
        chk("init_cycles",       64'(n),            64'd32);
        chk("init_rd_data_held", 64'(bus.rd_data),  64'd0);
        chk("init_pend_cnt",     64'(bus.pend_cnt), 64'd0);

        // Every register reads zero and non-pending after the sweep.
        for (int i = 0; i < 16; i++)
            cycle(2'b11, 5'(i), 5'(i + 16), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Directed vectors with hand-computed expectations.
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].re, tbl[i].a0, tbl[i].a1, tbl[i].we, tbl[i].wa, tbl[i].wd,
                  tbl[i].ie, tbl[i].ia);
            chk($sformatf("vec%0d_d0", i),  64'(bus.rd_data[31:0]),  64'(tbl[i].d0));
            chk($sformatf("vec%0d_d1", i),  64'(bus.rd_data[63:32]), 64'(tbl[i].d1));
            chk($sformatf("vec%0d_p", i),   64'(bus.rd_pend),        64'(tbl[i].p));
            chk($sformatf("vec%0d_cnt", i), 64'(bus.pend_cnt),       64'(tbl[i].cnt));
        end

        // Random traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++)
            cycle(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));

        // Drain pending state, then issue r1..r4 and reset mid-stream.
        for (int i = 0; i < 32; i++)
            cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0);
        cycle(2'b11, 5'd6, 5'd6, 1'b1, 5'd6, 32'hCAFE, 1'b1, 5'd1);
        cycle(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,    1'b1, 5'd2);
        cycle(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,    1'b1, 5'd3);
        cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h99,   1'b1, 5'd4);
        chk("mid_pend_cnt_before", 64'(bus.pend_cnt), 64'd4);

        rst_n = 1'b0;
        #1;
        chk("mid_rst_pend_cnt",  64'(bus.pend_cnt),  64'd0);
        chk("mid_rst_init_done", 64'(bus.init_done), 64'd0);
        chk("mid_rst_rd_data",   64'(bus.rd_data),   64'd0);
        chk("mid_rst_rd_pend",   64'(bus.rd_pend),   64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        model_reset();
        wait_init(n);
        chk("reinit_cycles", 64'(n), 64'd32);
        for (int i = 0; i < 16; i++)
            cycle(2'b11, 5'(i), 5'(i + 16), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
